dot_product_4bit: RTL and testbench
===================================

DOT_PRODUCT_4BIT -- requirements
Module: dot_product_4bit

Interface
REQ-001 SHALL have parameter: LEN, 4, number of operand pairs per dot product (>= 2).
REQ-002 SHALL have parameter: ACC_W, 10, accumulator/result width; SHALL be >= 8 + clog2(LEN).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port: clear  input  1  synchronous abort of the current dot product.
REQ-006 SHALL have port: in_valid  input  1  operand pair valid.
REQ-007 SHALL have port: in_ready  output  1  block can accept an operand pair.
REQ-008 SHALL have port: in_a  input  4  unsigned operand A.
REQ-009 SHALL have port: in_b  input  4  unsigned operand B.
REQ-010 SHALL have port: out_valid  output  1  result valid.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: out_sum  output  ACC_W  unsigned sum of LEN products.

Function
REQ-013 SHALL implement two states: ACCUM and DONE.
REQ-014 In ACCUM: in_ready = 1, out_valid = 0; in DONE: in_ready = 0, out_valid = 1.
REQ-015 Input accept = in_valid & in_ready at a clock edge; out accept = out_valid & out_ready.
REQ-016 Per input accept: acc <= acc + in_a*in_b (8-bit unsigned product, zero-extended to ACC_W); cnt <= cnt + 1.
REQ-017 On the accept with cnt == LEN-1: SHALL register final acc, reset cnt to 0, go to DONE.
REQ-018 Latency: out_valid SHALL assert the cycle after the LEN-th input accept.
REQ-019 out_sum SHALL equal acc and remain stable while out_valid=1 and out_ready=0.
REQ-020 On out accept in DONE: go to ACCUM, acc <= 0; in_ready SHALL assert the following cycle.
REQ-021 in_valid gaps SHALL be tolerated; cnt and acc hold when no accept occurs.
REQ-022 Arithmetic SHALL NOT overflow under REQ-002; no saturation or wrap logic.
REQ-023 clear = 1 (either state): next state ACCUM, acc = 0, cnt = 0; clear has priority over same-cycle input or output accept; the discarded pair is not counted.
REQ-024 out_sum SHALL read 0 whenever in ACCUM.

Reset
REQ-025 On rst = 1: state = ACCUM, acc = 0, cnt = 0, out_valid = 0, in_ready = 1 the cycle after the reset edge, out_sum = 0.
REQ-026 rst SHALL have priority over clear and all handshakes, including mid-accumulation and in DONE.
REQ-027 No output SHALL be X after the first clock edge with rst = 1.

Structure
REQ-028 State encoding typedef and constants (LEN default, ACC_W default, PROD_W = 8) SHALL live in shared package mult_pkg.
REQ-029 Product SHALL come from one combinational sub-module, mult4_comb (4x4 unsigned -> 8-bit), instantiated once.
REQ-030 cnt width SHALL be clog2(LEN); no other counters or memories.

Verification
REQ-031 LEN=4, pairs (3,5),(2,7),(0,9),(1,1) back-to-back -> out_valid next cycle, out_sum = 30.
REQ-032 LEN=4, four pairs (15,15) with 1-3 idle cycles between -> out_sum = 900, in_ready held 1 through the gaps.
REQ-033 Result pending, out_ready low 5 cycles -> out_sum stable at 900, in_ready = 0, in_valid ignored; out_ready high -> in_ready = 1 next cycle, next sum starts from 0.
REQ-034 Two pairs (4,4),(2,3) accepted, then clear with in_valid high -> pair dropped; four pairs (1,1) -> out_sum = 4.
REQ-035 rst asserted after 3 accepts or during DONE -> out_valid = 0, in_ready = 1, out_sum = 0; next four (2,2) -> out_sum = 16.
REQ-036 Out accept with in_valid high in the same cycle -> that pair not accepted; accumulation restarts the cycle after.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the 4-bit dot-product block.
package mult_pkg;

   localparam int unsigned LEN_DEF   = 4;
   localparam int unsigned ACC_W_DEF = 10;
   localparam int unsigned PROD_W    = 8;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

endpackage

// File: rtl/mult4_comb.sv
// Purely combinational 4x4 unsigned multiplier producing an 8-bit product.
module mult4_comb
   import mult_pkg::*;
(
   input  logic [3:0]        i_a,
   input  logic [3:0]        i_b,
   output logic [PROD_W-1:0] o_p
);

   always_comb begin
      o_p = {4'b0000, i_a} * {4'b0000, i_b};
   end

endmodule

// File: rtl/dot_product_4bit.sv
// Accumulates LEN unsigned 4x4 products with valid/ready handshakes on both sides;
// the sum is presented in DONE until the consumer accepts it.
module dot_product_4bit
   import mult_pkg::*;
#(
   parameter int unsigned LEN   = LEN_DEF,
   parameter int unsigned ACC_W = ACC_W_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum
);

   localparam int unsigned      CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

   state_t             r_state;
   state_t             w_next;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [PROD_W-1:0]  w_prod;
   logic               w_in_acc;
   logic               w_out_acc;
   logic               w_last;

   mult4_comb u_mult (
      .i_a (in_a),
      .i_b (in_b),
      .o_p (w_prod)
   );

   assign w_in_acc  = in_valid  & in_ready;
   assign w_out_acc = out_valid & out_ready;
   assign w_last    = (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_next;
      end
   end

   // clear overrides any handshake completing in the same cycle
   always_comb begin
      w_next = r_state;
      if (clear) begin
         w_next = ACCUM;
      end else begin
         case (r_state)
            ACCUM:   if (w_in_acc && w_last) w_next = DONE;
            DONE:    if (w_out_acc)          w_next = ACCUM;
            default: w_next = ACCUM;
         endcase
      end
   end

   always_comb begin
      in_ready  = (r_state == ACCUM);
      out_valid = (r_state == DONE);
      out_sum   = (r_state == DONE) ? r_acc : '0;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_in_acc) begin
         r_acc <= r_acc + {{(ACC_W - PROD_W){1'b0}}, w_prod};
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end else if (w_out_acc) begin
         r_acc <= '0;
      end
   end

endmodule

// File: tb/tb_dot_product_4bit.sv
// Directed self-checking bench for dot_product_4bit (LEN=4, ACC_W=10).
module tb_dot_product_4bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_sum;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   dot_product_4bit #(.LEN(4), .ACC_W(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pair(input logic [3:0] a, input logic [3:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_out_sum"},   {22'd0, out_sum},   32'd0);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = 4'd0; in_b = 4'd0;
      cyc(); cyc();
      rst = 1'b0;
      chk_idle("reset");

      // back-to-back: 15+14+0+1 = 30
      pair(4'd3, 4'd5);
      pair(4'd2, 4'd7);
      pair(4'd0, 4'd9);
      chk("t1_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("t1_mid_sum",   {22'd0, out_sum},   32'd0);
      pair(4'd1, 4'd1);
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_ready", {31'd0, in_ready},  32'd0);
      chk("t1_sum",   {22'd0, out_sum},   32'd30);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk_idle("t1_after");

      // gapped 15*15 x4 = 900
      pair(4'd15, 4'd15);
      cyc();
      chk("t2_gap1_ready", {31'd0, in_ready}, 32'd1);
      pair(4'd15, 4'd15);
      cyc(); cyc();
      chk("t2_gap2_ready", {31'd0, in_ready}, 32'd1);
      chk("t2_gap2_valid", {31'd0, out_valid}, 32'd0);
      pair(4'd15, 4'd15);
      cyc(); cyc(); cyc();
      chk("t2_gap3_ready", {31'd0, in_ready}, 32'd1);
      pair(4'd15, 4'd15);
      chk("t2_valid", {31'd0, out_valid}, 32'd1);
      chk("t2_sum",   {22'd0, out_sum},   32'd900);

      // backpressure: result holds, inputs ignored
      in_valid = 1'b1; in_a = 4'd7; in_b = 4'd7;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t3_hold_sum",   {22'd0, out_sum},   32'd900);
         chk("t3_hold_ready", {31'd0, in_ready},  32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk_idle("t3_release");
      pair(4'd2, 4'd3);
      pair(4'd1, 4'd1);
      pair(4'd1, 4'd1);
      pair(4'd1, 4'd1);
      chk("t3_next_sum", {22'd0, out_sum}, 32'd9);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;

      // clear mid-accumulation drops the concurrent pair and resets count
      pair(4'd4, 4'd4);
      pair(4'd2, 4'd3);
      clear = 1'b1; in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9;
      cyc();
      clear = 1'b0; in_valid = 1'b0;
      chk_idle("t4_clear");
      pair(4'd1, 4'd1);
      pair(4'd1, 4'd1);
      chk("t4_two_valid", {31'd0, out_valid}, 32'd0);
      pair(4'd1, 4'd1);
      pair(4'd1, 4'd1);
      chk("t4_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_sum",   {22'd0, out_sum},   32'd4);
      // clear in DONE wins over the output handshake
      clear = 1'b1; out_ready = 1'b1;
      cyc();
      clear = 1'b0; out_ready = 1'b0;
      chk_idle("t4_clear_done");

      // reset after three accepts
      pair(4'd3, 4'd3);
      pair(4'd3, 4'd3);
      pair(4'd3, 4'd3);
      rst = 1'b1; clear = 1'b1; in_valid = 1'b1; in_a = 4'd3; in_b = 4'd3;
      cyc();
      rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
      chk_idle("t5_rst_mid");
      pair(4'd2, 4'd2);
      pair(4'd2, 4'd2);
      pair(4'd2, 4'd2);
      pair(4'd2, 4'd2);
      chk("t5_sum", {22'd0, out_sum}, 32'd16);
      // reset in DONE
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk_idle("t5_rst_done");
      pair(4'd2, 4'd2);
      pair(4'd2, 4'd2);
      pair(4'd2, 4'd2);
      pair(4'd2, 4'd2);
      chk("t5_sum2", {22'd0, out_sum}, 32'd16);

      // out accept with in_valid high: that pair is not taken
      out_ready = 1'b1; in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15;
      cyc();
      out_ready = 1'b0; in_valid = 1'b0;
      chk_idle("t6_release");
      pair(4'd1, 4'd1);
      pair(4'd1, 4'd1);
      pair(4'd1, 4'd1);
      chk("t6_three_valid", {31'd0, out_valid}, 32'd0);
      pair(4'd1, 4'd1);
      chk("t6_valid", {31'd0, out_valid}, 32'd1);
      chk("t6_sum",   {22'd0, out_sum},   32'd4);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
